// File: rtl/sigma_np_pkg.sv
// Shared definitions for the N-sample accumulator: mode encodings and the
// sign-magnitude to two's-complement helper.
package sigma_np_pkg;

  localparam logic MODE_BLOCK = 1'b0;
  localparam logic MODE_SLIDE = 1'b1;

  // Converts a dw-bit sign-magnitude value to two's complement (-0 becomes 0).
  function automatic logic [31:0] sm2tc(input logic [31:0] raw, input int unsigned dw);
    logic [31:0] mag;
    logic        sign;
    mag  = raw & ((32'd1 << (dw - 1)) - 32'd1);
    sign = |(raw & (32'd1 << (dw - 1)));
    return sign ? (~mag + 32'd1) : mag;
  endfunction

endpackage

// File: rtl/sigma_np_if.sv
// Sample-side and result-side signals of the accumulator, bundled for
// the ADC front end (master) and the accumulator itself (slave).
interface sigma_np_if #(
  parameter int DW    = 8,
  parameter int LOG2N = 4
);
  localparam int OW = DW + LOG2N;

  logic [DW-1:0] data_in;
  logic          syn_in;
  logic          mode;
  logic          avg_en;
  logic          clr;
  logic [OW-1:0] data_out;
  logic          syn_out;

  modport master (
    output data_in, syn_in, mode, avg_en, clr,
    input  data_out, syn_out
  );

  modport slave (
    input  data_in, syn_in, mode, avg_en, clr,
    output data_out, syn_out
  );

endinterface

// File: rtl/sigma_np_dline.sv
// N x DW circular delay line for the sliding window; dout shows the oldest
// sample (the slot about to be overwritten) before the write lands.
module sigma_np_dline #(
  parameter int DW    = 8,
  parameter int LOG2N = 4
) (
  input  logic          clk,
  input  logic          res,
  input  logic          we,
  input  logic          clr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  localparam int N = 1 << LOG2N;

  logic [DW-1:0]    mem [N];
  logic [LOG2N-1:0] wr_ptr_reg;

  assign dout = mem[wr_ptr_reg];

  // Contents are never cleared: the fill counter upstream masks stale slots.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res)     wr_ptr_reg <= '0;
    else if (clr) wr_ptr_reg <= '0;
    else if (we)  wr_ptr_reg <= wr_ptr_reg + LOG2N'(1);
  end

endmodule

// File: rtl/sigma_np.sv
// N-sample accumulator: edge-detects the sample strobe, converts the sample
// and produces either a decimated block sum or a sliding-window sum.
module sigma_np
  import sigma_np_pkg::*;
#(
  parameter int DW    = 8,
  parameter int LOG2N = 4,
  parameter int IN_SM = 1
) (
  input  logic clk,
  input  logic res,
  sigma_np_if.slave bus
);
  localparam int N  = 1 << LOG2N;
  localparam int OW = DW + LOG2N;

  logic                 syn_d_reg;
  logic                 mode_d_reg;
  logic                 syn_out_reg;
  logic signed [OW-1:0] sigma_reg;
  logic signed [OW-1:0] data_out_reg;
  logic [LOG2N-1:0]     cnt_reg;
  logic [LOG2N:0]       fill_reg;

  logic                 pulse;
  logic                 restart;
  logic                 full;
  logic                 dline_we;
  logic [LOG2N:0]       fill_next;
  logic [DW-1:0]        x_dw;
  logic [DW-1:0]        x_old_dw;
  logic signed [OW-1:0] x;
  logic signed [OW-1:0] x_old;
  logic signed [OW-1:0] sum_blk;
  logic signed [OW-1:0] sum_sld;

  function automatic logic signed [OW-1:0] scale(input logic signed [OW-1:0] s,
                                                 input logic avg);
    return avg ? (s >>> LOG2N) : s;
  endfunction

  assign pulse   = bus.syn_in & ~syn_d_reg;
  assign restart = bus.clr | (bus.mode != mode_d_reg);

  generate
    if (IN_SM != 0) begin : g_sm
      assign x_dw = DW'(sm2tc(32'(bus.data_in), DW));
    end else begin : g_tc
      assign x_dw = bus.data_in;
    end
  endgenerate

  assign x     = OW'($signed(x_dw));
  assign x_old = OW'($signed(x_old_dw));

  assign full      = (fill_reg == (LOG2N+1)'(N));
  assign fill_next = full ? fill_reg : fill_reg + 1'b1;
  assign sum_blk   = sigma_reg + x;
  assign sum_sld   = sigma_reg + x - (full ? x_old : '0);
  assign dline_we  = pulse & ~restart & (bus.mode == MODE_SLIDE);

  sigma_np_dline #(.DW(DW), .LOG2N(LOG2N)) u_dline (
    .clk  (clk),
    .res  (res),
    .we   (dline_we),
    .clr  (restart),
    .din  (x_dw),
    .dout (x_old_dw)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      syn_d_reg    <= 1'b0;
      mode_d_reg   <= MODE_BLOCK;
      syn_out_reg  <= 1'b0;
      sigma_reg    <= '0;
      data_out_reg <= '0;
      cnt_reg      <= '0;
      fill_reg     <= '0;
    end else begin
      syn_d_reg   <= bus.syn_in;
      mode_d_reg  <= bus.mode;
      syn_out_reg <= 1'b0;
      // A restart beats a coincident pulse, so that sample is dropped.
      if (restart) begin
        sigma_reg <= '0;
        cnt_reg   <= '0;
        fill_reg  <= '0;
      end else if (pulse) begin
        if (bus.mode == MODE_BLOCK) begin
          if (cnt_reg == LOG2N'(N - 1)) begin
            data_out_reg <= scale(sum_blk, bus.avg_en);
            syn_out_reg  <= 1'b1;
            sigma_reg    <= '0;
            cnt_reg      <= '0;
          end else begin
            sigma_reg <= sum_blk;
            cnt_reg   <= cnt_reg + LOG2N'(1);
          end
        end else begin
          sigma_reg <= sum_sld;
          fill_reg  <= fill_next;
          if (fill_next == (LOG2N+1)'(N)) begin
            data_out_reg <= scale(sum_sld, bus.avg_en);
            syn_out_reg  <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.data_out = data_out_reg;
  assign bus.syn_out  = syn_out_reg;

endmodule
